mig_ui_model: RTL and testbench

//   Responder end of the MIG 7-series user (app_*) interface: a synthesizable stand-in for the
//   MIG core, backed by on-chip RAM. The DDR2 controller drives it exactly as it drives the real

---
 rtl/mig_ui_model.sv | 158 +++++++++++++++
 tb/tb_mig_ui_model.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_ui_model.sv
// mig_ui_model: on-chip-RAM stand-in for the MIG 7-series app_* user interface.
// Models calibration delay, app_rdy backpressure, in-order command queue, write-data FIFO and fixed read latency.
module mig_ui_model #(
  parameter int MEM_AW         = 10,
  parameter int CALIB_CYCLES   = 64,
  parameter int RD_LAT         = 4,
  parameter int QDEPTH         = 4,
  parameter int REFRESH_PERIOD = 0
) (
  input  logic         ui_clk,
  input  logic         rst,
  input  logic [26:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         init_calib_complete,
  output logic         cmd_err
);
  localparam int QAW = $clog2(QDEPTH);
  localparam int NPS = RD_LAT - 1;
  localparam logic [QAW:0] QFULL = (QAW+1)'(QDEPTH);

  logic [15:0]       r_cal_cnt;
  logic              r_calib;
  logic [15:0]       r_ref_cnt;
  logic              r_ref_wrapped;
  logic              r_cq_rd   [QDEPTH];
  logic [MEM_AW-1:0] r_cq_addr [QDEPTH];
  logic [QAW-1:0]    r_cq_wp, r_cq_rp;
  logic [QAW:0]      r_cq_cnt;
  logic [127:0]      r_wdf_data [QDEPTH];
  logic [15:0]       r_wdf_mask [QDEPTH];
  logic [QAW-1:0]    r_wdf_wp, r_wdf_rp;
  logic [QAW:0]      r_wdf_cnt;
  logic [127:0]      r_mem [2**MEM_AW];
  logic [NPS-1:0]    r_pv;
  logic [127:0]      r_pd [NPS];
  logic              r_app_rdy, r_wdf_rdy, r_rd_valid, r_cmd_err;
  logic [127:0]      r_rd_data;

  logic              w_cmd_hs, w_cmd_legal, w_cq_push, w_cq_pop, w_wdf_push;
  logic              w_head_rd, w_do_rd, w_do_wr, w_calib_nxt;
  logic              w_ref_wrapped_nxt, w_ref_win_nxt, w_err_set;
  logic [15:0]       w_ref_cnt_nxt;
  logic [QAW:0]      w_cq_cnt_nxt, w_wdf_cnt_nxt;
  logic [MEM_AW-1:0] w_head_addr;
  logic              w_unused_addr;

  assign w_unused_addr = ^{app_addr[26:MEM_AW+3], app_addr[2:0]};

  assign w_cmd_hs      = app_en & r_app_rdy;
  assign w_cmd_legal   = (app_cmd == 3'b000) | (app_cmd == 3'b001);
  assign w_cq_push     = w_cmd_hs & w_cmd_legal;
  assign w_wdf_push    = app_wdf_wren & r_wdf_rdy;
  assign w_head_rd     = r_cq_rd[r_cq_rp];
  assign w_head_addr   = r_cq_addr[r_cq_rp];
  // A write at the head waits for its data beat; nothing behind it may overtake.
  assign w_do_rd       = (r_cq_cnt != {(QAW+1){1'b0}}) & w_head_rd;
  assign w_do_wr       = (r_cq_cnt != {(QAW+1){1'b0}}) & !w_head_rd & (r_wdf_cnt != {(QAW+1){1'b0}});
  assign w_cq_pop      = w_do_rd | w_do_wr;
  assign w_cq_cnt_nxt  = r_cq_cnt + (QAW+1)'(w_cq_push) - (QAW+1)'(w_cq_pop);
  assign w_wdf_cnt_nxt = r_wdf_cnt + (QAW+1)'(w_wdf_push) - (QAW+1)'(w_do_wr);
  assign w_calib_nxt   = r_calib | (r_cal_cnt == 16'(CALIB_CYCLES - 1));
  assign w_err_set     = (w_cmd_hs & !w_cmd_legal) | (w_wdf_push & !app_wdf_end);
  assign w_ref_win_nxt = w_ref_wrapped_nxt & (w_ref_cnt_nxt < 16'd4);

  // Next refresh-counter state; the first window opens one full period after calibration.
  always_comb begin
    w_ref_cnt_nxt     = r_ref_cnt;
    w_ref_wrapped_nxt = r_ref_wrapped;
    if ((REFRESH_PERIOD > 0) && r_calib) begin
      if (r_ref_cnt == 16'(REFRESH_PERIOD - 1)) begin
        w_ref_cnt_nxt     = 16'd0;
        w_ref_wrapped_nxt = 1'b1;
      end else begin
        w_ref_cnt_nxt = r_ref_cnt + 16'd1;
      end
    end else begin
      w_ref_cnt_nxt     = r_ref_cnt;
      w_ref_wrapped_nxt = r_ref_wrapped;
    end
  end

  // Control state, queue pointers, read-valid pipeline and registered outputs.
  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      r_cal_cnt     <= 16'd0;
      r_calib       <= 1'b0;
      r_ref_cnt     <= 16'd0;
      r_ref_wrapped <= 1'b0;
      r_cq_wp       <= {QAW{1'b0}};
      r_cq_rp       <= {QAW{1'b0}};
      r_cq_cnt      <= {(QAW+1){1'b0}};
      r_wdf_wp      <= {QAW{1'b0}};
      r_wdf_rp      <= {QAW{1'b0}};
      r_wdf_cnt     <= {(QAW+1){1'b0}};
      r_app_rdy     <= 1'b0;
      r_wdf_rdy     <= 1'b0;
      r_pv          <= {NPS{1'b0}};
      r_rd_valid    <= 1'b0;
      r_rd_data     <= 128'd0;
      r_cmd_err     <= 1'b0;
    end else begin
      if (!r_calib) r_cal_cnt <= r_cal_cnt + 16'd1;
      r_calib       <= w_calib_nxt;
      r_ref_cnt     <= w_ref_cnt_nxt;
      r_ref_wrapped <= w_ref_wrapped_nxt;
      if (w_cq_push)  r_cq_wp  <= r_cq_wp + QAW'(1);
      if (w_cq_pop)   r_cq_rp  <= r_cq_rp + QAW'(1);
      if (w_wdf_push) r_wdf_wp <= r_wdf_wp + QAW'(1);
      if (w_do_wr)    r_wdf_rp <= r_wdf_rp + QAW'(1);
      r_cq_cnt      <= w_cq_cnt_nxt;
      r_wdf_cnt     <= w_wdf_cnt_nxt;
      r_app_rdy     <= w_calib_nxt & (w_cq_cnt_nxt != QFULL) & !w_ref_win_nxt;
      r_wdf_rdy     <= w_calib_nxt & (w_wdf_cnt_nxt != QFULL);
      r_pv[0]       <= w_do_rd;
      for (int i = 1; i < NPS; i++) r_pv[i] <= r_pv[i-1];
      r_rd_valid    <= r_pv[NPS-1];
      r_rd_data     <= r_pd[NPS-1];
      if (w_err_set) r_cmd_err <= 1'b1;
    end
  end

  // Queue/FIFO storage, RAM and read-data pipeline; contents survive reset.
  always_ff @(posedge ui_clk) begin
    if (w_cq_push) begin
      r_cq_rd[r_cq_wp]   <= app_cmd[0];
      r_cq_addr[r_cq_wp] <= app_addr[MEM_AW+2:3];
    end
    if (w_wdf_push) begin
      r_wdf_data[r_wdf_wp] <= app_wdf_data;
      r_wdf_mask[r_wdf_wp] <= app_wdf_mask;
    end
    if (w_do_wr) begin
      for (int b = 0; b < 16; b++) begin
        if (!r_wdf_mask[r_wdf_rp][b]) r_mem[w_head_addr][8*b +: 8] <= r_wdf_data[r_wdf_rp][8*b +: 8];
      end
    end
    if (w_do_rd) r_pd[0] <= r_mem[w_head_addr];
    for (int i = 1; i < NPS; i++) r_pd[i] <= r_pd[i-1];
  end

  assign app_rdy             = r_app_rdy;
  assign app_wdf_rdy         = r_wdf_rdy;
  assign app_rd_data         = r_rd_data;
  assign app_rd_data_valid   = r_rd_valid;
  assign app_rd_data_end     = r_rd_valid;
  assign init_calib_complete = r_calib;
  assign cmd_err             = r_cmd_err;
endmodule

// File: tb/tb_mig_ui_model.sv
// tb_mig_ui_model: directed steps against mig_ui_model (REFRESH_PERIOD=32) with a read-data scoreboard.
`timescale 1ns/1ps
module tb_mig_ui_model;
  localparam int RD_LAT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [26:0]  app_addr = 27'd0;
  logic [2:0]   app_cmd = 3'd0;
  logic         app_en = 1'b0;
  logic         app_rdy;
  logic [127:0] app_wdf_data = 128'd0;
  logic [15:0]  app_wdf_mask = 16'd0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b1;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid, app_rd_data_end, init_calib_complete, cmd_err;

  mig_ui_model #(.MEM_AW(10), .CALIB_CYCLES(64), .RD_LAT(RD_LAT), .QDEPTH(4), .REFRESH_PERIOD(32)) dut (
    .ui_clk(clk), .rst(rst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete), .cmd_err(cmd_err));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_vcyc = 0;
  logic [127:0] exp_q [$];
  logic [127:0] mdl [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor runs 1ns after each edge; the stimulus process runs at 2ns.
  always begin
    @(posedge clk);
    #1;
    if (rst) chk("rd_end", app_rd_data_end, app_rd_data_valid);
    if (app_rd_data_valid) begin
      n_valid++;
      last_vcyc = cyc;
      chk("valid_has_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("rd_data", app_rd_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d, input logic [15:0] m);
    logic [127:0] r;
    r = old;
    for (int i = 0; i < 16; i++) if (!m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_wr(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
    int w = int'(a[12:3]);
    mdl[w] = merge(mdl.exists(w) ? mdl[w] : 128'd0, d, m);
  endtask

  task automatic issue_cmd(input logic [2:0] c, input logic [26:0] a, input bit push_exp,
                           output int waited, output int acc_cyc);
    logic rdy_b;
    bit done = 1'b0;
    int w = int'(a[12:3]);
    waited = 0;
    acc_cyc = -1;
    app_en = 1'b1; app_cmd = c; app_addr = a;
    while (!done && waited < 100) begin
      rdy_b = app_rdy;
      tick();
      waited++;
      if (rdy_b) done = 1'b1;
    end
    app_en = 1'b0;
    chk("cmd_accept", done, 1'b1);
    if (done) begin
      acc_cyc = cyc;
      if (push_exp) exp_q.push_back(mdl.exists(w) ? mdl[w] : 128'd0);
    end
  endtask

  task automatic send_wdf(input logic [127:0] d, input logic [15:0] m);
    logic rdy_b;
    bit done = 1'b0;
    int n = 0;
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1'b1;
    while (!done && n < 100) begin
      rdy_b = app_wdf_rdy;
      tick();
      n++;
      if (rdy_b) done = 1'b1;
    end
    app_wdf_wren = 1'b0;
    chk("wdf_accept", done, 1'b1);
  endtask

  task automatic wr_both(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
    logic cr, dr;
    bit cdone = 1'b0;
    bit ddone = 1'b0;
    int n = 0;
    model_wr(a, d, m);
    app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1'b1;
    while (!(cdone && ddone) && n < 100) begin
      cr = app_rdy & app_en;
      dr = app_wdf_rdy & app_wdf_wren;
      tick();
      n++;
      if (cr) begin cdone = 1'b1; app_en = 1'b0; end
      if (dr) begin ddone = 1'b1; app_wdf_wren = 1'b0; end
    end
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
    chk("wr_both_accept", cdone & ddone, 1'b1);
  endtask

  task automatic wait_valids(input int target);
    int n = 0;
    while (n_valid < target && n < 60) begin
      tick();
      n++;
    end
    chk("valid_count", n_valid, target);
  endtask

  task automatic wait_calib(input string tag);
    bit early = 1'b0;
    int n = 0;
    while (!init_calib_complete && n < 200) begin
      if (app_rdy | app_wdf_rdy) early = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_cycles"}, n, 64);
    chk({tag, "_no_early_rdy"}, early, 1'b0);
    chk({tag, "_rdy_at_calib"}, {app_rdy, app_wdf_rdy}, 2'b11);
  endtask

  initial begin
    logic [127:0] d0, d1, d2, d3;
    int waited, acc, v0, cal0, mism, first_low;
    logic expv;
    d0 = 128'hFEDC_BA98_7654_3210_0000_0000_1122_3344;
    d1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d2 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_9999;
    d3 = 128'h3030_3131_3232_3333_3434_3535_3636_3737;

    // 1. reset, calibration, refresh pattern on an idle interface
    #1 rst = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {app_rdy, app_wdf_rdy, init_calib_complete, app_rd_data_valid, cmd_err}, 5'b0);
    rst = 1'b1;
    wait_calib("calib");
    cal0 = cyc;
    mism = 0;
    first_low = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      expv = !((k >= 32) && ((k % 32) < 4));
      if (app_rdy !== expv) mism++;
      if (first_low < 0 && !app_rdy) first_low = k;
    end
    chk("refresh_first_low", first_low, 32);
    chk("refresh_pattern_mismatches", mism, 0);

    // 2. write then read same word; fixed latency; aliased address reads the same word
    wr_both(27'h20, d0, 16'h0000);
    v0 = n_valid;
    issue_cmd(3'b001, 27'h20, 1'b1, waited, acc);
    wait_valids(v0 + 1);
    chk("rd_latency", last_vcyc - acc, RD_LAT);
    issue_cmd(3'b001, 27'h2025, 1'b1, waited, acc);
    wait_valids(v0 + 2);

    // 3. write cmd without data stalls a queued read; masked bytes keep old value
    wr_both(27'h10, d1, 16'h0000);
    repeat (3) tick();
    model_wr(27'h10, d2, 16'h000F);
    issue_cmd(3'b000, 27'h10, 1'b0, waited, acc);
    v0 = n_valid;
    issue_cmd(3'b001, 27'h10, 1'b1, waited, acc);
    repeat (5) tick();
    chk("no_valid_before_wdf", n_valid, v0);
    send_wdf(d2, 16'h000F);
    wait_valids(v0 + 1);

    // 4. stalled write plus 3 reads fills the queue; then 5 reads drain in order
    model_wr(27'h30, d3, 16'h0000);
    issue_cmd(3'b000, 27'h30, 1'b0, waited, acc);
    v0 = n_valid;
    issue_cmd(3'b001, 27'h20, 1'b1, waited, acc);
    issue_cmd(3'b001, 27'h10, 1'b1, waited, acc);
    issue_cmd(3'b001, 27'h30, 1'b1, waited, acc);
    chk("rdy_low_when_full", app_rdy, 1'b0);
    repeat (3) tick();
    chk("rdy_low_full_hold", app_rdy, 1'b0);
    send_wdf(d3, 16'h0000);
    issue_cmd(3'b001, 27'h20, 1'b1, waited, acc);
    issue_cmd(3'b001, 27'h30, 1'b1, waited, acc);
    wait_valids(v0 + 5);

    // 5. app_en held across a refresh window, then an illegal command
    waited = 0;
    while (((cyc - cal0) % 32) != 0 && waited < 40) begin
      tick();
      waited++;
    end
    chk("rdy_low_in_refresh", app_rdy, 1'b0);
    v0 = n_valid;
    issue_cmd(3'b001, 27'h20, 1'b1, waited, acc);
    chk("refresh_hold_wait", waited, 5);
    wait_valids(v0 + 1);
    chk("cmd_err_clear", cmd_err, 1'b0);
    issue_cmd(3'b010, 27'h20, 1'b0, waited, acc);
    tick();
    chk("cmd_err_set", cmd_err, 1'b1);
    v0 = n_valid;
    repeat (10) tick();
    chk("illegal_no_data", n_valid, v0);

    // 6. reset with reads queued behind a stalled write
    issue_cmd(3'b000, 27'h40, 1'b0, waited, acc);
    for (int i = 0; i < 3; i++) issue_cmd(3'b001, 27'h20, 1'b0, waited, acc);
    v0 = n_valid;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {app_rdy, app_wdf_rdy, init_calib_complete, app_rd_data_valid, cmd_err}, 5'b0);
    tick();
    tick();
    rst = 1'b1;
    wait_calib("recal");
    repeat (20) tick();
    chk("no_stale_valid", n_valid, v0);
    issue_cmd(3'b001, 27'h20, 1'b1, waited, acc);
    wait_valids(v0 + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached (errors=%0d)", n_err);
    $fatal(1, "watchdog");
  end
endmodule
